// File: rtl/iir_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with bus lock in front of a shared IIR core.
// Optional strobe watchdog enabled by defining IIR_ARB_TIMEOUT_EN.
module iir_wb_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_dat_i,
   input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
   input  logic                    m0_we_i,
   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   output logic [DATA_WIDTH-1:0]   m0_dat_o,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_dat_i,
   input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
   input  logic                    m1_we_i,
   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   output logic [DATA_WIDTH-1:0]   m1_dat_o,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   output logic [DATA_WIDTH/8-1:0] s_sel_o,
   output logic                    s_we_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   output logic [1:0]              grant_o
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t r_state;
   state_t w_next;
   logic   r_last_owner;
   logic   w_to;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == OWN0 && !m0_cyc_i)
            r_last_owner <= 1'b0;
         else if (r_state == OWN1 && !m1_cyc_i)
            r_last_owner <= 1'b1;
      end
   end

   // Release always passes through IDLE; contention favours the non-last owner.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               w_next = r_last_owner ? OWN0 : OWN1;
            else if (m0_cyc_i)
               w_next = OWN0;
            else if (m1_cyc_i)
               w_next = OWN1;
         end
         OWN0:    if (!m0_cyc_i) w_next = IDLE;
         OWN1:    if (!m1_cyc_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

`ifdef IIR_ARB_TIMEOUT_EN
   logic [15:0] r_to_cnt;

   assign w_to = (r_to_cnt == 16'(TIMEOUT_CYCLES));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_to_cnt <= '0;
      else if (w_to || !s_stb_o || s_ack_i || s_err_i)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + 16'd1;
   end
`else
   assign w_to = 1'b0;
`endif

   always_comb begin
      grant_o  = 2'b00;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      unique case (r_state)
         OWN0: begin
            grant_o  = 2'b01;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i & ~w_to;
            s_stb_o  = m0_stb_i & ~w_to;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | w_to;
         end
         OWN1: begin
            grant_o  = 2'b10;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i & ~w_to;
            s_stb_o  = m1_stb_i & ~w_to;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | w_to;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_iir_wb_arbiter.sv
// Self-checking bench for iir_wb_arbiter: directed scenarios plus an ack scoreboard.
// Timeout expectations follow IIR_ARB_TIMEOUT_EN.
module tb_iir_wb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
   logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
   logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
   logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [1:0]    grant_o;

   typedef struct {
      int            m;
      logic [DW-1:0] d;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   iir_wb_arbiter #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i),
      .m0_sel_i(m0_sel_i),
      .m0_we_i (m0_we_i),
      .m0_cyc_i(m0_cyc_i),
      .m0_stb_i(m0_stb_i),
      .m0_dat_o(m0_dat_o),
      .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i),
      .m1_sel_i(m1_sel_i),
      .m1_we_i (m1_we_i),
      .m1_cyc_i(m1_cyc_i),
      .m1_stb_i(m1_stb_i),
      .m1_dat_o(m1_dat_o),
      .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_sel_o (s_sel_o),
      .s_we_o  (s_we_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_dat_i (s_dat_i),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .grant_o (grant_o)
   );

   // Every forwarded ack must match the oldest expected beat for that master.
   always @(negedge clk) begin
      if (m0_ack_o === 1'b1) begin
         checks++;
         if (sb.size() == 0 || sb[0].m != 0 || sb[0].d !== m0_dat_o) begin
            errors++;
            $display("FAIL sb_m0_ack: got dat=%h, expected queue size=%0d", m0_dat_o, sb.size());
         end
         if (sb.size() != 0) void'(sb.pop_front());
      end
      if (m1_ack_o === 1'b1) begin
         checks++;
         if (sb.size() == 0 || sb[0].m != 1 || sb[0].d !== m1_dat_o) begin
            errors++;
            $display("FAIL sb_m1_ack: got dat=%h, expected queue size=%0d", m1_dat_o, sb.size());
         end
         if (sb.size() != 0) void'(sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
      m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
      m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
   endtask

   task automatic req(input int m, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
      if (m == 0) begin
         m0_adr_i = a; m0_dat_i = d; m0_sel_i = '1;
         m0_we_i = we; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      end else begin
         m1_adr_i = a; m1_dat_i = d; m1_sel_i = '1;
         m1_we_i = we; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      end
   endtask

   task automatic drop(input int m);
      if (m == 0) begin
         m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      end else begin
         m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      end
   endtask

   task automatic slave_beat(input int m, input logic [DW-1:0] d);
      tick();
      s_ack_i = 1'b1;
      s_dat_i = d;
      sb.push_back('{m, d});
   endtask

   task automatic wait_grant(input logic [1:0] g, output int n);
      n = 0;
      @(negedge clk);
      while (grant_o !== g && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      req(0, 1'b1, '1, '1);
      req(1, 1'b1, '1, '1);
      s_ack_i = 1'b1; s_err_i = 1'b1; s_dat_i = 32'hDEADBEEF;
      repeat (3) @(negedge clk);
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL reset_grant: got %b want 00", grant_o);
      end
      checks++;
      if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
         errors++; $display("FAIL reset_s_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o});
      end
      checks++;
      if ({s_adr_o, s_dat_o, s_sel_o} !== '0) begin
         errors++; $display("FAIL reset_s_bus: got adr=%h dat=%h sel=%h want 0", s_adr_o, s_dat_o, s_sel_o);
      end
      checks++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
         errors++; $display("FAIL reset_m_resp: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
      end
      checks++;
      if ({m0_dat_o, m1_dat_o} !== '0) begin
         errors++; $display("FAIL reset_m_dat: got %h %h want 0", m0_dat_o, m1_dat_o);
      end
      tick();
      idle_inputs();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_contention();
      tick();
      req(0, 1'b0, 32'h20, '0);
      req(1, 1'b0, 32'h30, '0);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL contend_registered: got %b want 00", grant_o);
      end
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b01 || s_adr_o !== 32'h20) begin
         errors++; $display("FAIL contend_first: got grant=%b adr=%h want 01/20", grant_o, s_adr_o);
      end
      slave_beat(0, 32'hAA);
      @(negedge clk);
      checks++;
      if (m1_ack_o !== 1'b0 || m1_dat_o !== '0) begin
         errors++; $display("FAIL contend_m1_quiet: got ack=%b dat=%h want 0", m1_ack_o, m1_dat_o);
      end
      tick();
      s_ack_i = 1'b0;
      drop(0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL contend_idle: got %b want 00", grant_o);
      end
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b10 || s_adr_o !== 32'h30) begin
         errors++; $display("FAIL contend_second: got grant=%b adr=%h want 10/30", grant_o, s_adr_o);
      end
      slave_beat(1, 32'hBB);
      @(negedge clk);
      tick();
      s_ack_i = 1'b0;
      drop(1);
      repeat (2) @(negedge clk);
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL contend_end: got %b want 00", grant_o);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] eg;
      int         own;
      tick();
      req(0, 1'b0, 32'h40, '0);
      req(1, 1'b0, 32'h50, '0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         own = k % 2;
         eg  = (own == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if (grant_o !== eg) begin
            errors++; $display("FAIL fair_grant_%0d: got %b want %b", k, grant_o, eg);
         end
         slave_beat(own, 32'h100 + k);
         @(negedge clk);
         tick();
         s_ack_i = 1'b0;
         drop(own);
         if (k == 3) drop(1 - own);
         @(negedge clk);
         tick();
         if (k < 3) req(own, 1'b0, (own == 0) ? 32'h40 : 32'h50, '0);
         @(negedge clk);
         checks++;
         if (grant_o !== 2'b00) begin
            errors++; $display("FAIL fair_idle_%0d: got %b want 00", k, grant_o);
         end
      end
   endtask

   task automatic test_lock();
      logic [DW-1:0] rd [3];
      rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
      tick();
      req(1, 1'b0, 32'h60, '0);
      @(negedge clk);
      tick();
      req(0, 1'b0, 32'h70, '0);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b10) begin
         errors++; $display("FAIL lock_grant_m1: got %b want 10", grant_o);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         s_ack_i = 1'b1;
         s_dat_i = rd[i];
         sb.push_back('{1, rd[i]});
         @(negedge clk);
         checks++;
         if (grant_o !== 2'b10) begin
            errors++; $display("FAIL lock_hold_%0d: got %b want 10", i, grant_o);
         end
      end
      tick();
      s_ack_i = 1'b0;
      drop(1);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL lock_idle: got %b want 00", grant_o);
      end
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL lock_m0_after: got %b want 01", grant_o);
      end
      slave_beat(0, 32'hD);
      @(negedge clk);
      tick();
      s_ack_i = 1'b0;
      drop(0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      tick();
      req(0, 1'b1, 32'h10, 32'h1234);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
         errors++; $display("FAIL single_registered: got grant=%b cyc=%b want 00/0", grant_o, s_cyc_o);
      end
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL single_grant: got %b want 01", grant_o);
      end
      checks++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !==
          {3'b111, 4'hF, 32'h10, 32'h1234}) begin
         errors++; $display("FAIL single_req: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1/1/1/f/10/1234",
                            s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o);
      end
      tick();
      @(negedge clk);
      slave_beat(0, '0);
      @(negedge clk);
      tick();
      s_ack_i = 1'b0;
      drop(0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL single_release: got %b want 00", grant_o);
      end
   endtask

   task automatic test_abort();
      int n;
      tick();
      req(0, 1'b0, 32'h80, '0);
      wait_grant(2'b01, n);
      checks++;
      if (n >= 20) begin
         errors++; $display("FAIL abort_grant: got %b want 01", grant_o);
      end
      tick();
      m0_cyc_i = 1'b0;
      @(negedge clk);
      checks++;
      if (s_cyc_o !== 1'b0) begin
         errors++; $display("FAIL abort_cyc_follow: got %b want 0", s_cyc_o);
      end
      tick();
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'h99;
      @(negedge clk);
      checks++;
      if ({m0_ack_o, m0_dat_o, grant_o} !== '0) begin
         errors++; $display("FAIL abort_discard: got ack=%b dat=%h grant=%b want 0", m0_ack_o, m0_dat_o, grant_o);
      end
      tick();
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_ack_err();
      int n;
      tick();
      req(0, 1'b0, 32'h90, '0);
      wait_grant(2'b01, n);
      tick();
      s_ack_i = 1'b1;
      s_err_i = 1'b1;
      s_dat_i = 32'h55;
      sb.push_back('{0, 32'h55});
      @(negedge clk);
      checks++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b1100) begin
         errors++; $display("FAIL ack_err_fwd: got %b want 1100", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
      end
      tick();
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      int   n;
      int   pulses;
      int   at;
      logic stb_at;
      pulses = 0; at = -1; stb_at = 1'bx;
      tick();
      req(0, 1'b0, 32'hA0, '0);
      wait_grant(2'b01, n);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (m0_err_o === 1'b1) begin
            pulses++;
            at = i;
            stb_at = s_stb_o;
         end
      end
      tick();
      drop(0);
      repeat (2) @(negedge clk);
`ifdef IIR_ARB_TIMEOUT_EN
      checks++;
      if (pulses != 1 || at != 4) begin
         errors++; $display("FAIL timeout_pulse: got pulses=%0d at=%0d want 1 at 4", pulses, at);
      end
      checks++;
      if (stb_at !== 1'b0) begin
         errors++; $display("FAIL timeout_stb: got %b want 0", stb_at);
      end
`else
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL timeout_off: got pulses=%0d at=%0d stb=%b want 0", pulses, at, stb_at);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      tick();
      req(1, 1'b0, 32'hB0, '0);
      wait_grant(2'b10, n);
      checks++;
      if (n >= 20) begin
         errors++; $display("FAIL rstmid_grant: got %b want 10", grant_o);
      end
      tick();
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({grant_o, s_cyc_o, s_stb_o, s_adr_o} !== '0) begin
         errors++; $display("FAIL rstmid_outputs: got grant=%b cyc=%b stb=%b adr=%h want 0",
                            grant_o, s_cyc_o, s_stb_o, s_adr_o);
      end
      s_ack_i = 1'b1;
      s_dat_i = 32'h77;
      #1;
      checks++;
      if ({m1_ack_o, m1_dat_o, m0_ack_o} !== '0) begin
         errors++; $display("FAIL rstmid_no_ack: got ack=%b dat=%h want 0", m1_ack_o, m1_dat_o);
      end
      tick();
      idle_inputs();
      tick();
      rst_ni = 1'b1;
      tick();
      req(0, 1'b0, 32'hC0, '0);
      req(1, 1'b0, 32'hC4, '0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL rstmid_m0_wins: got %b want 01", grant_o);
      end
      tick();
      drop(0);
      drop(1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      test_reset();
      test_contention();
      test_fairness();
      test_lock();
      test_single();
      test_abort();
      test_ack_err();
      test_timeout();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d pending beats want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iir_wb_arbiter.md
IIR_WB_ARBITER -- requirements
Module: iir_wb_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, meaning the Wishbone address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the Wishbone data width; sel width is DATA_WIDTH/8.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the unacknowledged-strobe cycle limit; legal range 1..65535.
REQ-004 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 mN_adr_i, mN_dat_i, mN_sel_i, mN_we_i, mN_cyc_i, mN_stb_i  inputs  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1/1  Wishbone master-side request, for N=0 and N=1.
REQ-007 mN_dat_o, mN_ack_o, mN_err_o  outputs  DATA_WIDTH/1/1  Wishbone response to master N.
REQ-008 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  outputs  widths as REQ-006  request to the shared IIR core slave.
REQ-009 s_dat_i, s_ack_i, s_err_i  inputs  DATA_WIDTH/1/1  response from the IIR core slave.
REQ-010 grant_o  output  2  one-hot current owner; bit N means master N; 2'b00 means idle.

Function
REQ-011 State machine states SHALL be IDLE, OWN0 and OWN1, with a last_owner register.
REQ-012 From IDLE with only mN_cyc_i high, the next state SHALL be OWNN.
REQ-013 From IDLE with both cyc high, the master that is not last_owner SHALL be granted (round-robin).
REQ-014 The grant SHALL be registered: slave cyc/stb assert no earlier than the cycle after the master's cyc is first seen in IDLE.
REQ-015 OWNN SHALL hold while mN_cyc_i is high, including across multiple stb/ack beats (bus lock).
REQ-016 OWNN SHALL return to IDLE on the first cycle that mN_cyc_i is low, and last_owner SHALL be set to N.
REQ-017 No cycle SHALL grant the other master in the same cycle as the release; re-arbitration occurs from IDLE.
REQ-018 In OWNN, all s_* request outputs SHALL combinationally equal mN_* inputs; s_dat_i, s_ack_i and s_err_i SHALL route to master N only.
REQ-019 The non-owning master SHALL see dat_o=0, ack_o=0 and err_o=0.
REQ-020 In IDLE, all s_* outputs SHALL be 0.
REQ-021 Master cyc dropping mid-transfer (stb high, no ack) SHALL release as per REQ-016; any later slave ack SHALL be discarded.
REQ-022 Simultaneous s_ack_i and s_err_i SHALL both be forwarded unchanged.

Reset
REQ-023 While rst_ni is low, state SHALL be IDLE and grant_o=0.
REQ-024 While rst_ni is low, all s_* outputs and all mN_dat_o/ack_o/err_o SHALL be 0.
REQ-025 While rst_ni is low, last_owner SHALL be 1, so master 0 wins the first contention, and the timeout counter SHALL be 0.
REQ-026 Reset assertion mid-transfer SHALL abandon the transfer immediately; no ack SHALL be forwarded after it.

Configuration
REQ-027 Macro IIR_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL increment each cycle s_stb_o=1 and s_ack_i=0.
REQ-028 With IIR_ARB_TIMEOUT_EN, the counter SHALL clear on ack, on err, or when stb is low.
REQ-029 With IIR_ARB_TIMEOUT_EN, when the counter equals TIMEOUT_CYCLES, the arbiter SHALL pulse mN_err_o for exactly one cycle to the owner, force s_stb_o and s_cyc_o low that cycle, and clear the counter.
REQ-030 IIR_ARB_TIMEOUT_EN undefined: no counter SHALL exist, and err_o SHALL be only the forwarded s_err_i.

Verification
REQ-031 Single master: m0 write adr=0x10, dat=0x1234, slave acks 2 cycles after stb -> grant_o=01 one cycle after cyc; s_dat_o=0x1234; m0_ack_o one pulse; grant_o=00 after cyc drops.
REQ-032 Contention from reset: m0 and m1 raise cyc in the same cycle -> m0 is served first; m1 is granted in the second cycle after m0 releases; m1 sees no ack during m0's ownership.
REQ-033 Fairness: both masters request continuously for 4 transfers -> grant sequence is 01,10,01,10 with an idle cycle between each.
REQ-034 Lock: m1 issues 3 back-to-back reads (s_dat_i=0xA,0xB,0xC) holding cyc while m0 requests -> m1 receives A,B,C; m0 is granted only afterwards.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=4): slave never acks -> m0_err_o pulses once 4 cycles after stb, s_stb_o=0 that cycle, m0_ack_o never asserts; macro off -> no err pulse.
REQ-036 Reset mid-transfer: assert rst_ni low with m1 stb pending, then ack arrives -> all outputs 0 and m1_ack_o stays 0; after release, m0 wins the next contention.
